// File: rtl/coord_pkg.sv
// coord_pkg: shared widths and loader state encoding for the coordinate table loader.
package coord_pkg;
  localparam int COORD_W = 16;
  localparam int CSUM_W = 8;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_X = 3'd1,
    ST_LOAD_Z = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;
endpackage

// File: rtl/coord_dp_ram.sv
// coord_dp_ram: one write port, one registered read port (read-before-write, out-of-range reads 0).
module coord_dp_ram
  import coord_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [COORD_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [COORD_W-1:0] rdata_o
);
  logic [COORD_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  always_ff @(posedge clk)
    if (rst) rdata_o <= '0;
    else rdata_o <= (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;
endmodule

// File: rtl/coord_table_loader.sv
// coord_table_loader: byte-stream loader for the X/Z coordinate tables with registered read port.
// Optional trailing checksum byte enabled by COORD_CHECKSUM_EN.
module coord_table_loader
  import coord_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  load_done,
  output logic                  table_valid,
  output logic                  load_err,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [COORD_W-1:0]    x_out,
  output logic [COORD_W-1:0]    z_out
);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(NUM_CHANNELS - 1);
`ifdef COORD_CHECKSUM_EN
  localparam state_e Z_NEXT = ST_CHECK;
`else
  localparam state_e Z_NEXT = ST_DONE;
`endif
  state_e state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic phase_q, phase_d, tv_q, tv_d, done_q, done_d;
  logic [7:0] lo_q, lo_d;
  logic acc, wr, last;
`ifdef COORD_CHECKSUM_EN
  logic [CSUM_W-1:0] sum_q, sum_d;
  logic err_q, err_d;
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif
  assign s_ready = state_q inside {ST_LOAD_X, ST_LOAD_Z, ST_CHECK};
  assign acc = s_valid && s_ready && !load_start;
  assign last = cnt_q == LAST;
  assign wr = acc && phase_q && (state_q == ST_LOAD_X || state_q == ST_LOAD_Z);
  assign load_done = done_q;
  assign table_valid = tv_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    phase_d = phase_q;
    lo_d = lo_q;
    tv_d = tv_q;
    done_d = 1'b0;
`ifdef COORD_CHECKSUM_EN
    sum_d = sum_q;
    err_d = err_q;
`endif
    if (load_start) begin
      state_d = ST_LOAD_X;
      cnt_d = '0;
      phase_d = 1'b0;
      tv_d = 1'b0;
`ifdef COORD_CHECKSUM_EN
      sum_d = '0;
      err_d = 1'b0;
`endif
    end else if (acc) begin
`ifdef COORD_CHECKSUM_EN
      sum_d = sum_q + s_data;
      if (state_q == ST_CHECK) begin
        state_d = ST_DONE;
        done_d = 1'b1;
        tv_d = sum_d == '0;
        err_d = sum_d != '0;
      end else
`endif
      if (!phase_q) begin
        phase_d = 1'b1;
        lo_d = s_data;
      end else begin
        phase_d = 1'b0;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = state_q == ST_LOAD_X ? ST_LOAD_Z : Z_NEXT;
        if (last && state_d == ST_DONE) begin
          done_d = 1'b1;
          tv_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      phase_q <= 1'b0;
      lo_q <= '0;
      tv_q <= 1'b0;
      done_q <= 1'b0;
`ifdef COORD_CHECKSUM_EN
      sum_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      lo_q <= lo_d;
      tv_q <= tv_d;
      done_q <= done_d;
`ifdef COORD_CHECKSUM_EN
      sum_q <= sum_d;
      err_q <= err_d;
`endif
    end
  coord_dp_ram #(.DEPTH(NUM_CHANNELS), .AW(ADDR_WIDTH)) u_x (
    .clk(clk), .rst(rst), .we_i(wr && state_q == ST_LOAD_X), .waddr_i(cnt_q[ADDR_WIDTH-1:0]),
    .wdata_i({s_data, lo_q}), .raddr_i(addr), .rdata_o(x_out)
  );
  coord_dp_ram #(.DEPTH(NUM_CHANNELS), .AW(ADDR_WIDTH)) u_z (
    .clk(clk), .rst(rst), .we_i(wr && state_q == ST_LOAD_Z), .waddr_i(cnt_q[ADDR_WIDTH-1:0]),
    .wdata_i({s_data, lo_q}), .raddr_i(addr), .rdata_o(z_out)
  );
endmodule
